// File: rtl/delay_tap_ctrl.sv
// Tap-select controller for a bank of delay lines. It tracks how much history
// has been shifted in and blanks the output while a tap change settles.
module delay_tap_ctrl #(
    parameter int DEPTH0 = 30,
    parameter int DEPTH1 = 45,
    parameter int DEPTH2 = 60,
    parameter int DEPTH3 = 90,
    parameter int GUARD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       din_valid,
    input  logic       flush,
    input  logic       sel_valid,
    input  logic [1:0] sel_data,
    output logic       sel_ready,
    output logic       shift_en,
    output logic [1:0] tap_sel,
    output logic       dout_valid,
    output logic       busy,
    output logic [6:0] fill_cnt
);

    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [1:0]    tap_d;
    logic [6:0]    fill_d;
    logic [6:0]    active_depth;
    logic          accept;
    logic          depth_met;

    function automatic logic [6:0] depth_of(input logic [1:0] t);
        case (t)
            2'd0:    depth_of = 7'(DEPTH0);
            2'd1:    depth_of = 7'(DEPTH1);
            2'd2:    depth_of = 7'(DEPTH2);
            default: depth_of = 7'(DEPTH3);
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FILL;
            guard_q  <= '0;
            tap_sel  <= 2'd0;
            fill_cnt <= 7'd0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            tap_sel  <= tap_d;
            fill_cnt <= fill_d;
        end
    end

    // Handshake: a tap change is taken on an edge where sel_valid and
    // sel_ready are both high; sel_ready never depends on sel_valid.
    always_comb begin
        shift_en     = din_valid && ena;
        sel_ready    = ena && !rst && (state_q != ST_SWITCH);
        accept       = sel_valid && sel_ready;
        dout_valid   = (state_q == ST_RUN) && ena;
        busy         = (state_q == ST_FILL) || (state_q == ST_SWITCH);
        active_depth = depth_of(tap_sel);
        depth_met    = (fill_cnt >= active_depth);

        state_d = state_q;
        guard_d = guard_q;
        tap_d   = tap_sel;
        fill_d  = fill_cnt;

        if (ena) begin
            // Flush wins over a same-edge shift; the counter saturates at the deepest tap.
            if (flush) begin
                fill_d = 7'd0;
            end else if (shift_en && (fill_cnt < 7'(DEPTH3))) begin
                fill_d = fill_cnt + 7'd1;
            end

            case (state_q)
                ST_FILL, ST_RUN: begin
                    if (accept) begin
                        tap_d   = sel_data;
                        guard_d = GW'(GUARD);
                        state_d = ST_SWITCH;
                    end else if (flush) begin
                        state_d = ST_FILL;
                    end else if ((state_q == ST_FILL) && depth_met) begin
                        state_d = ST_RUN;
                    end
                end
                ST_SWITCH: begin
                    if (guard_q <= GW'(1)) begin
                        guard_d = '0;
                        state_d = depth_met ? ST_RUN : ST_FILL;
                    end else begin
                        guard_d = guard_q - GW'(1);
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    guard_d = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Directed bench for delay_tap_ctrl: fill, saturation, tap switching, flush,
// enable freeze and asynchronous reset, with hand-computed expectations.
module tb_delay_tap_ctrl;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       din_valid;
    logic       flush;
    logic       sel_valid;
    logic [1:0] sel_data;
    logic       sel_ready;
    logic       shift_en;
    logic [1:0] tap_sel;
    logic       dout_valid;
    logic       busy;
    logic [6:0] fill_cnt;

    int total;
    int bad;

    delay_tap_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .din_valid  (din_valid),
        .flush      (flush),
        .sel_valid  (sel_valid),
        .sel_data   (sel_data),
        .sel_ready  (sel_ready),
        .shift_en   (shift_en),
        .tap_sel    (tap_sel),
        .dout_valid (dout_valid),
        .busy       (busy),
        .fill_cnt   (fill_cnt)
    );

    // clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are then driven and outputs sampled 2ns later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic request(input logic [1:0] t, input logic with_flush);
        sel_valid = 1'b1;
        sel_data  = t;
        flush     = with_flush;
        tick();
        sel_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        ena       = 1'b1;
        din_valid = 1'b0;
        flush     = 1'b0;
        sel_valid = 1'b0;
        sel_data  = 2'd0;

        // reset values (ena high: sel_ready must still be low)
        ticks(2);
        check("rst_fill", fill_cnt, 0);
        check("rst_tap", tap_sel, 0);
        check("rst_busy", busy, 1);
        check("rst_dvalid", dout_valid, 0);
        check("rst_ready", sel_ready, 0);
        rst = 1'b0;
        #1;
        check("fill_ready", sel_ready, 1);

        // continuous fill: RUN follows the 31st edge, counter saturates at 90
        din_valid = 1'b1;
        #1;
        check("shift_en_on", shift_en, 1);
        ticks(30);
        check("fill30_cnt", fill_cnt, 30);
        check("fill30_dvalid", dout_valid, 0);
        tick();
        check("fill31_dvalid", dout_valid, 1);
        check("fill31_cnt", fill_cnt, 31);
        check("fill31_busy", busy, 0);
        ticks(70);
        check("sat_cnt", fill_cnt, 90);
        din_valid = 1'b0;

        // RUN at 90, switch to tap 3: blanked 2 cycles then RUN
        #1;
        check("run_ready", sel_ready, 1);
        request(2'd3, 1'b0);
        check("sw3_tap", tap_sel, 3);
        check("sw3_ready", sel_ready, 0);
        check("sw3_dv1", dout_valid, 0);
        check("sw3_busy", busy, 1);
        tick();
        check("sw3_dv2", dout_valid, 0);
        tick();
        check("sw3_run", dout_valid, 1);
        check("sw3_tap_run", tap_sel, 3);

        // flush alone: back to FILL at 0
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_cnt", fill_cnt, 0);
        check("flush_busy", busy, 1);
        check("flush_dv", dout_valid, 0);

        // build 50, move to tap 1 (45): RUN after the guard
        din_valid = 1'b1;
        ticks(50);
        din_valid = 1'b0;
        check("fifty_cnt", fill_cnt, 50);
        check("fifty_dv", dout_valid, 0);
        request(2'd1, 1'b0);
        tick();
        tick();
        check("tap1_run", dout_valid, 1);
        check("tap1_tap", tap_sel, 1);

        // RUN at 50, tap 2 (60): SWITCH 2 cycles then FILL, RUN after 10 shifts + 1 edge
        request(2'd2, 1'b0);
        check("sw2_dv1", dout_valid, 0);
        tick();
        check("sw2_dv2", dout_valid, 0);
        check("sw2_ready", sel_ready, 0);
        tick();
        check("sw2_fill_busy", busy, 1);
        check("sw2_fill_ready", sel_ready, 1);
        check("sw2_fill_dv", dout_valid, 0);
        din_valid = 1'b1;
        ticks(10);
        din_valid = 1'b0;
        check("sw2_cnt60", fill_cnt, 60);
        check("sw2_dv60", dout_valid, 0);
        tick();
        check("sw2_run", dout_valid, 1);

        // flush together with tap change to 0
        request(2'd0, 1'b1);
        check("fx_cnt", fill_cnt, 0);
        check("fx_tap", tap_sel, 0);
        check("fx_ready", sel_ready, 0);
        check("fx_dv", dout_valid, 0);
        ticks(2);
        check("fx_fill_ready", sel_ready, 1);
        check("fx_fill_busy", busy, 1);
        din_valid = 1'b1;
        ticks(30);
        check("fx_cnt30", fill_cnt, 30);
        check("fx_dv30", dout_valid, 0);
        tick();
        check("fx_dv31", dout_valid, 1);
        din_valid = 1'b0;

        // enable freeze mid-FILL: flush and requests ignored
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        din_valid = 1'b1;
        ticks(10);
        check("frz_pre", fill_cnt, 10);
        ena       = 1'b0;
        sel_valid = 1'b1;
        sel_data  = 2'd3;
        flush     = 1'b1;
        #1;
        check("frz_shift", shift_en, 0);
        check("frz_ready", sel_ready, 0);
        check("frz_dv", dout_valid, 0);
        ticks(5);
        check("frz_cnt", fill_cnt, 10);
        check("frz_tap", tap_sel, 0);
        check("frz_busy", busy, 1);
        ena       = 1'b1;
        sel_valid = 1'b0;
        flush     = 1'b0;
        tick();
        check("frz_resume", fill_cnt, 11);
        check("frz_resume_dv", dout_valid, 0);
        din_valid = 1'b0;

        // asynchronous reset in the middle of SWITCH
        request(2'd1, 1'b0);
        check("ar_sw_busy", busy, 1);
        check("ar_sw_tap", tap_sel, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_tap", tap_sel, 0);
        check("ar_cnt", fill_cnt, 0);
        check("ar_busy", busy, 1);
        check("ar_dv", dout_valid, 0);
        check("ar_ready", sel_ready, 0);
        tick();
        rst       = 1'b0;
        din_valid = 1'b1;
        ticks(30);
        check("ar_cnt30", fill_cnt, 30);
        check("ar_dv30", dout_valid, 0);
        check("ar_tap30", tap_sel, 0);
        tick();
        check("ar_dv31", dout_valid, 1);
        din_valid = 1'b0;

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
